life_gen_sequencer: RTL and testbench
=====================================

Name: life_gen_sequencer

Overview:
- Controller that owns the selector-side port of the 4-row x 16-column alive-cell memory.
- On a manual step pulse or an auto-run timer tick, it reads all four rows, computes the next Conway generation (B3/S23) and writes all four rows back.
- Reports busy, done, generation count, and stable/extinct status to the top-level.
- The VGA read port is untouched; the debug preload path is arbitrated by aborting.

Parameters:
- ROWS, 4, number of memory rows; fixed at 4, address width 2.
- COLS, 16, cells per row; bit i of a row is column i.
- PERIOD, 25000000, auto-run interval in clk cycles; must be >= 16.
- WRAP, 0, 0 = cells beyond the grid edge are dead; 1 = toroidal wrap in rows and columns.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- step, input, 1, single-cycle request for one generation.
- run, input, 1, level; enables auto-run at PERIOD.
- debug, input, 1, memory preload active; aborts the sequencer.
- array_selector, output, 2, row address to memory, registered.
- alive_in_selector, output, 16, write data to memory, registered.
- write_enb, output, 1, memory write strobe, registered.
- alive_out_selector, input, 16, memory read data; valid the cycle after the address is presented.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when a generation write-back completes.
- gen_count, output, 16, generations completed; wraps 0xFFFF -> 0.
- stable, output, 1, last generation equal to its predecessor.
- extinct, output, 1, last generation all-zero.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, array_selector 0, alive_in_selector 0, write_enb 0, busy 0, done 0, gen_count 0, stable 0, extinct 0, timer 0, row buffers 0.
- Triggers:
  - In IDLE with run=1, the timer counts every cycle. At PERIOD-1 it fires a tick and clears.
  - With run=0 the timer holds at 0. The timer does not count outside IDLE.
  - Trigger = step OR tick, sampled in IDLE only. step while busy is dropped, not queued.
  - step and tick in the same cycle start exactly one generation.
- States: IDLE -> READ -> COMPUTE -> WRITE -> DONE -> IDLE.
- Timing, with C1 the first cycle after the trigger edge:
  - READ, C1..C5:
    - array_selector = 0,1,2,3,3 in C1..C5.
    - Row k is captured from alive_out_selector at the end of cycle C(k+2), one-cycle memory latency.
    - write_enb = 0 throughout.
  - COMPUTE, C6:
    - All next-gen rows are computed from the four buffered rows and registered.
    - Neighbour count is 0..8 per cell.
    - A cell is alive next if count == 3, or if count == 2 and the cell is alive now.
    - Edge handling per WRAP: row -1 / row 4 and column -1 / column 16 are 0 (WRAP=0) or the opposite edge (WRAP=1).
  - WRITE, C7..C10:
    - array_selector = 0..3, alive_in_selector = next row, write_enb = 1.
  - DONE, C11:
    - write_enb = 0, done = 1, gen_count increments.
    - stable <= (next == current, all rows); extinct <= (all next rows == 0).
  - Return to IDLE at C12. busy is high C1..C11. Trigger-to-done latency is 11 cycles.
- debug = 1 in any state:
  - Next state IDLE; write_enb forced 0 in the same cycle as the debug register update.
  - No further memory writes; done not pulsed; gen_count, stable and extinct unchanged; timer cleared.
  - A partially completed write-back is abandoned.
  - Triggers are ignored while debug = 1.
- reset mid-operation: returns to reset values next edge, no done pulse, no write after the reset edge.
- stable and extinct are only updated in DONE and hold otherwise.

Test Plan:
- Blinker, WRAP=0:
  - Stimulus: memory rows {0000,0700,0000,0000}, pulse step.
  - Required: write_enb high exactly C7..C10; rows written {0200,0200,0200,0000}; done at C11; gen_count=1; stable=0; extinct=0.
  - Second step restores {0000,0700,0000,0000}; gen_count=2.
- Block still life:
  - Stimulus: rows {0000,0018,0018,0000}, pulse step.
  - Required: written rows identical; stable=1; extinct=0.
- Extinction and wrap:
  - WRAP=0, rows {0001,0000,0000,0000} -> all zero, extinct=1.
  - WRAP=1, rows {8001,0000,0000,8001} (2x2 block across the corners) -> unchanged, stable=1.
- Auto-run and collision, PERIOD=16:
  - Stimulus: run=1, blinker loaded.
  - Required: done pulses every 16+11 cycles; step pulsed during busy is dropped; step coinciding with the tick yields a single done.
- Abort:
  - Assert debug at C8: write_enb=0 from C9, no done, back in IDLE, gen_count unchanged.
  - Repeat with reset at C8: all outputs return to reset values.

Source files
------------

// File: rtl/life_gen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : life_gen_sequencer
//  Function : Reads the 4x16 alive-cell memory, computes the next Conway
//             generation (B3/S23) and writes it back, on step or auto-run.
//  Revision : 1.0
// ============================================================================
module life_gen_sequencer #(
    parameter int ROWS   = 4,
    parameter int COLS   = 16,
    parameter int PERIOD = 25000000,
    parameter int WRAP   = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            step,
    input  logic            run,
    input  logic            debug,
    output logic [1:0]      array_selector,
    output logic [COLS-1:0] alive_in_selector,
    output logic            write_enb,
    input  logic [COLS-1:0] alive_out_selector,
    output logic            busy,
    output logic            done,
    output logic [15:0]     gen_count,
    output logic            stable,
    output logic            extinct
);

    localparam int              C_TW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [C_TW-1:0] C_TICK_AT = C_TW'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_COMPUTE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                    state_q,   state_d;
    logic [2:0]                cnt_q,     cnt_d;
    logic [C_TW-1:0]           timer_q,   timer_d;
    logic [1:0]                sel_q,     sel_d;
    logic [COLS-1:0]           wdata_q,   wdata_d;
    logic                      we_q,      we_d;
    logic                      done_q,    done_d;
    logic [15:0]               gen_q,     gen_d;
    logic                      stable_q,  stable_d;
    logic                      extinct_q, extinct_d;
    logic [ROWS-1:0][COLS-1:0] row_q,     row_d;
    logic [ROWS-1:0][COLS-1:0] next_q,    next_d;

    logic [ROWS+1:0][COLS+1:0] w_ext;
    logic [ROWS-1:0][COLS-1:0] w_next;
    logic                      w_tick;
    logic                      w_trigger;

    // Bit 0 is column -1 and bit COLS+1 is column COLS of the padded row.
    function automatic logic [COLS+1:0] pad_row(input logic [COLS-1:0] row);
        if (WRAP != 0)
            pad_row = {row[0], row, row[COLS-1]};
        else
            pad_row = {1'b0, row, 1'b0};
    endfunction

    always_comb begin
        w_ext = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_ext[r+1] = pad_row(row_q[r]);
        end
        if (WRAP != 0) begin
            w_ext[0]      = pad_row(row_q[ROWS-1]);
            w_ext[ROWS+1] = pad_row(row_q[0]);
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [3:0] w_cnt;
            assign w_cnt = 4'(w_ext[r][c])   + 4'(w_ext[r][c+1])   + 4'(w_ext[r][c+2])
                         + 4'(w_ext[r+1][c])                       + 4'(w_ext[r+1][c+2])
                         + 4'(w_ext[r+2][c]) + 4'(w_ext[r+2][c+1]) + 4'(w_ext[r+2][c+2]);
            assign w_next[r][c] = (w_cnt == 4'd3) || ((w_cnt == 4'd2) && row_q[r][c]);
        end
    end

    assign w_tick    = (state_q == S_IDLE) && run && (timer_q == C_TICK_AT);
    assign w_trigger = step || w_tick;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        done_d    = 1'b0;
        gen_d     = gen_q;
        stable_d  = stable_q;
        extinct_d = extinct_q;
        row_d     = row_q;
        next_d    = next_q;

        if (debug) begin
            state_d = S_IDLE;
            timer_d = '0;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!run || w_tick)
                        timer_d = '0;
                    else
                        timer_d = timer_q + C_TW'(1);
                    if (w_trigger) begin
                        state_d = S_READ;
                        cnt_d   = 3'd0;
                        sel_d   = 2'd0;
                    end
                end
                S_READ: begin
                    // Read data trails the address by one cycle.
                    if (cnt_q != 3'd0)
                        row_d[2'(cnt_q - 3'd1)] = alive_out_selector;
                    if (cnt_q == 3'd4) begin
                        state_d = S_COMPUTE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        sel_d = (cnt_q < 3'd3) ? 2'(cnt_q + 3'd1) : 2'd3;
                    end
                end
                S_COMPUTE: begin
                    next_d  = w_next;
                    state_d = S_WRITE;
                    cnt_d   = 3'd0;
                    sel_d   = 2'd0;
                    wdata_d = w_next[0];
                    we_d    = 1'b1;
                end
                S_WRITE: begin
                    if (cnt_q == 3'd3) begin
                        state_d   = S_DONE;
                        cnt_d     = 3'd0;
                        sel_d     = 2'd0;
                        done_d    = 1'b1;
                        gen_d     = gen_q + 16'd1;
                        stable_d  = (next_q == row_q);
                        extinct_d = (next_q == '0);
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        sel_d   = 2'(cnt_q + 3'd1);
                        wdata_d = next_q[2'(cnt_q + 3'd1)];
                        we_d    = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            timer_q   <= '0;
            sel_q     <= 2'd0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            gen_q     <= 16'd0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
            row_q     <= '0;
            next_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            done_q    <= done_d;
            gen_q     <= gen_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
            row_q     <= row_d;
            next_q    <= next_d;
        end
    end

    assign array_selector    = sel_q;
    assign alive_in_selector = wdata_q;
    assign write_enb         = we_q;
    assign busy              = (state_q != S_IDLE);
    assign done              = done_q;
    assign gen_count         = gen_q;
    assign stable            = stable_q;
    assign extinct           = extinct_q;

endmodule
`default_nettype wire

// File: tb/tb_life_gen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_life_gen_sequencer
//  Function : Directed bench for life_gen_sequencer with a 1-cycle memory model.
//  Revision : 1.0
// ============================================================================
module tb_life_gen_sequencer;

    logic clk = 1'b0;
    logic reset, step, run, debug;

    logic [1:0]  sel0, sel1;
    logic [15:0] wd0, wd1, out0, out1;
    logic        we0, we1, busy0, busy1, done0, done1;
    logic        stab0, stab1, ext0, ext1;
    logic [15:0] gen0, gen1;

    logic [3:0][15:0] mem0, mem1;
    logic [63:0]      ld_val0, ld_val1;
    logic             ld_en0, ld_en1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    life_gen_sequencer #(.ROWS(4), .COLS(16), .PERIOD(16), .WRAP(0)) u_dut0 (
        .clk(clk), .reset(reset), .step(step), .run(run), .debug(debug),
        .array_selector(sel0), .alive_in_selector(wd0), .write_enb(we0),
        .alive_out_selector(out0), .busy(busy0), .done(done0),
        .gen_count(gen0), .stable(stab0), .extinct(ext0)
    );

    life_gen_sequencer #(.ROWS(4), .COLS(16), .PERIOD(16), .WRAP(1)) u_dut1 (
        .clk(clk), .reset(reset), .step(step), .run(run), .debug(debug),
        .array_selector(sel1), .alive_in_selector(wd1), .write_enb(we1),
        .alive_out_selector(out1), .busy(busy1), .done(done1),
        .gen_count(gen1), .stable(stab1), .extinct(ext1)
    );

    // Memory: registered read, write on write_enb, bench preload port.
    always @(posedge clk) begin
        out0 <= mem0[sel0];
        out1 <= mem1[sel1];
        if (ld_en0)   mem0 <= ld_val0;
        else if (we0) mem0[sel0] <= wd0;
        if (ld_en1)   mem1 <= ld_val1;
        else if (we1) mem1[sel1] <= wd1;
    end

    function automatic logic [63:0] rows4(input logic [15:0] r0, r1, r2, r3);
        return {r3, r2, r1, r0};
    endfunction

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input logic [63:0] v0, input logic l1, input logic [63:0] v1);
        @(negedge clk);
        ld_val0 = v0; ld_val1 = v1;
        ld_en0  = 1'b1; ld_en1 = l1;
        @(negedge clk);
        ld_en0  = 1'b0; ld_en1 = 1'b0;
    endtask

    // Pulses step and records C1..C11 of dut0, then checks C12 is idle.
    task automatic run_step(input string tag);
        logic [10:0] we_h, dn_h, bz_h;
        logic [9:0]  sel_h;
        we_h = '0; dn_h = '0; bz_h = '0; sel_h = '0;
        step = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            step = 1'b0;
            we_h[k] = we0;
            dn_h[k] = done0;
            bz_h[k] = busy0;
            if (k < 5) sel_h[2*k +: 2] = sel0;
        end
        check_value({tag, "_we_cycles"},   64'(we_h),  64'h3C0);
        check_value({tag, "_done_cycles"}, 64'(dn_h),  64'h400);
        check_value({tag, "_busy_cycles"}, 64'(bz_h),  64'h7FF);
        check_value({tag, "_read_addrs"},  64'(sel_h), 64'h3E4);
        @(negedge clk);
        check_value({tag, "_idle_c12"}, 64'(busy0), 64'd0);
    endtask

    task automatic wait_done(input string tag, output int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < 200);
        if (!done0) check_value({tag, "_timeout"}, 64'd0, 64'd1);
        t = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d1, d2, d3, d4, n, nd;
        reset = 1'b1; step = 1'b0; run = 1'b0; debug = 1'b0;
        ld_en0 = 1'b0; ld_en1 = 1'b0; ld_val0 = '0; ld_val1 = '0;
        repeat (3) @(negedge clk);
        check_value("rst_sel",     64'(sel0),  64'd0);
        check_value("rst_wdata",   64'(wd0),   64'd0);
        check_value("rst_we",      64'(we0),   64'd0);
        check_value("rst_busy",    64'(busy0), 64'd0);
        check_value("rst_done",    64'(done0), 64'd0);
        check_value("rst_gen",     64'(gen0),  64'd0);
        check_value("rst_stable",  64'(stab0), 64'd0);
        check_value("rst_extinct", 64'(ext0),  64'd0);
        check_value("rst_dut1",    64'({busy1, done1, gen1, stab1, ext1}), 64'd0);
        reset = 1'b0;
        load_mem('0, 1'b1, '0);

        // Blinker, both phases
        load_mem(rows4(16'h0000, 16'h0700, 16'h0000, 16'h0000), 1'b0, '0);
        run_step("blink1");
        check_value("blink1_mem", mem0, rows4(16'h0200, 16'h0200, 16'h0200, 16'h0000));
        check_value("blink1_gen", 64'(gen0), 64'd1);
        check_value("blink1_flags", 64'({stab0, ext0}), 64'd0);
        run_step("blink2");
        check_value("blink2_mem", mem0, rows4(16'h0000, 16'h0700, 16'h0000, 16'h0000));
        check_value("blink2_gen", 64'(gen0), 64'd2);

        // Block still life
        load_mem(rows4(16'h0000, 16'h0018, 16'h0018, 16'h0000), 1'b0, '0);
        run_step("block");
        check_value("block_mem", mem0, rows4(16'h0000, 16'h0018, 16'h0018, 16'h0000));
        check_value("block_stable", 64'(stab0), 64'd1);
        check_value("block_extinct", 64'(ext0), 64'd0);
        check_value("block_gen", 64'(gen0), 64'd3);

        // Lone cell dies
        load_mem(rows4(16'h0001, 16'h0000, 16'h0000, 16'h0000), 1'b0, '0);
        run_step("lone");
        check_value("lone_mem", mem0, 64'd0);
        check_value("lone_extinct", 64'(ext0), 64'd1);
        check_value("lone_stable", 64'(stab0), 64'd0);
        check_value("lone_gen", 64'(gen0), 64'd4);

        // Corner block: survives only with wrap
        load_mem(rows4(16'h8001, 16'h0000, 16'h0000, 16'h8001), 1'b1,
                 rows4(16'h8001, 16'h0000, 16'h0000, 16'h8001));
        run_step("corner");
        check_value("corner_nowrap_mem", mem0, 64'd0);
        check_value("corner_nowrap_extinct", 64'(ext0), 64'd1);
        check_value("corner_wrap_mem", mem1, rows4(16'h8001, 16'h0000, 16'h0000, 16'h8001));
        check_value("corner_wrap_flags", 64'({stab1, ext1}), 64'b10);
        check_value("corner_gen", 64'(gen0), 64'd5);

        // Auto-run at PERIOD=16
        load_mem(rows4(16'h0000, 16'h0700, 16'h0000, 16'h0000), 1'b0, '0);
        run = 1'b1;
        t0 = cyc;
        wait_done("auto1", d1);
        check_value("auto_first_latency", 64'(d1 - t0), 64'd26);
        n = 0;
        while (busy0 && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (!busy0 && n < 50) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_done("auto2", d2);
        check_value("auto_period_busy_step", 64'(d2 - d1), 64'd27);
        wait_done("auto3", d3);
        check_value("auto_period_3", 64'(d3 - d2), 64'd27);
        repeat (16) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_done("auto4", d4);
        check_value("auto_collision_period", 64'(d4 - d3), 64'd27);
        run = 1'b0;
        nd = 0;
        repeat (40) begin @(negedge clk); if (done0) nd++; end
        check_value("auto_no_extra_done", 64'(nd), 64'd0);
        check_value("auto_gen", 64'(gen0), 64'd9);
        check_value("auto_mem", mem0, rows4(16'h0000, 16'h0700, 16'h0000, 16'h0000));

        // Debug abort at C8
        nd = 0;
        step = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            step = 1'b0;
            if (done0) nd++;
            if (k == 7) check_value("abort_we_c7", 64'(we0), 64'd1);
        end
        debug = 1'b1;
        @(negedge clk);
        check_value("abort_we_c9", 64'(we0), 64'd0);
        check_value("abort_busy_c9", 64'(busy0), 64'd0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        check_value("abort_step_ignored", 64'(busy0), 64'd0);
        debug = 1'b0;
        repeat (3) begin @(negedge clk); if (done0) nd++; end
        check_value("abort_no_done", 64'(nd), 64'd0);
        check_value("abort_gen", 64'(gen0), 64'd9);
        check_value("abort_mem", mem0, rows4(16'h0200, 16'h0200, 16'h0000, 16'h0000));

        // Reset abort at C8
        load_mem(rows4(16'h0000, 16'h0700, 16'h0000, 16'h0000), 1'b0, '0);
        step = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            step = 1'b0;
        end
        check_value("rabort_wdata_c8", 64'(wd0), 64'h0200);
        reset = 1'b1;
        @(negedge clk);
        check_value("rabort_sel",     64'(sel0),  64'd0);
        check_value("rabort_wdata",   64'(wd0),   64'd0);
        check_value("rabort_we",      64'(we0),   64'd0);
        check_value("rabort_busy",    64'(busy0), 64'd0);
        check_value("rabort_done",    64'(done0), 64'd0);
        check_value("rabort_gen",     64'(gen0),  64'd0);
        check_value("rabort_flags",   64'({stab0, ext0}), 64'd0);
        check_value("rabort_dut1",    64'({stab1, gen1}), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rabort_mem", mem0, rows4(16'h0200, 16'h0200, 16'h0000, 16'h0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
